pwm_level_spi_tx: RTL and testbench

SPI-side transmitter that drives the sclk/mosi link of the 7-channel PWM driver. It keeps a 7-entry shadow table of PWM levels, written by the host in any cycle. Each written channel is marked dirty, and the block serialises one 11-bit frame per dirty channel, in round-robin order. It is the host/controller end of the PWM driver's SPI input and generates all link timing from the system clock.

---
 rtl/pwm_level_spi_tx.sv | 155 +++++++++++++++
 tb/tb_pwm_level_spi_tx.sv | 224 ++++++++++++++++++++++
 2 files changed

// File: rtl/pwm_level_spi_tx.sv
// Host end of the 7-channel PWM driver's SPI link: a shadow table of PWM levels,
// with one 11-bit {addr, level} frame sent per dirty channel in round-robin order.
module pwm_level_spi_tx #(
    parameter int CLK_DIV    = 4,
    parameter int GAP_CYCLES = 2
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       wr_en,
    input  logic [2:0] wr_addr,
    input  logic [7:0] wr_data,
    output logic       sclk,
    output logic       mosi,
    output logic       busy,
    output logic [6:0] dirty,
    output logic       frame_done
);
    localparam int HW = $clog2(CLK_DIV) + 1;
    localparam int GW = $clog2(GAP_CYCLES + 1) + 1;
    localparam logic [HW-1:0] HALF_LAST = HW'(CLK_DIV - 1);
    localparam logic [GW-1:0] GAP_LAST  = GW'(GAP_CYCLES - 1);

    typedef enum logic [1:0] {IDLE, SHIFT, GAP} state_t;

    state_t        state_q, state_d;
    logic [7:0]    level_tbl [7];
    logic [6:0]    dirty_q;
    logic [2:0]    last_sent;
    logic [10:0]   shreg, shreg_d;
    logic [HW-1:0] half_cnt, half_d;
    logic [3:0]    bit_cnt, bit_d;
    logic [GW-1:0] gap_cnt, gap_d;
    logic          sclk_d, mosi_d, frame_done_d;
    logic          select;
    logic [3:0]    pick;
    logic          wr_ok;

    // Returns {found, idx}: first pending channel after 'last', wrapping 6 -> 0.
    function automatic logic [3:0] pick_next(input logic [6:0] pend, input logic [2:0] last);
        logic [3:0] res;
        logic [2:0] c;
        res = '0;
        c   = last;
        for (int i = 0; i < 7; i++) begin
            c = (c == 3'd6) ? 3'd0 : c + 3'd1;
            if (!res[3] && pend[c])
                res = {1'b1, c};
        end
        return res;
    endfunction

    assign pick  = pick_next(dirty_q, last_sent);
    assign wr_ok = wr_en && (wr_addr != 3'd7);
    assign dirty = dirty_q;

    always_comb begin
        // NOTE: every comb output gets a default first so no path can infer a latch.
        state_d      = state_q;
        select       = 1'b0;
        sclk_d       = sclk;
        mosi_d       = mosi;
        frame_done_d = 1'b0;
        half_d       = half_cnt;
        bit_d        = bit_cnt;
        gap_d        = gap_cnt;
        shreg_d      = shreg;
        case (state_q)
            IDLE: select = pick[3];
            SHIFT: begin
                if (half_cnt != HALF_LAST) begin
                    half_d = half_cnt + 1'b1;
                end else begin
                    half_d = '0;
                    if (!sclk) begin
                        sclk_d = 1'b1;
                    end else if (bit_cnt == 4'd10) begin
                        sclk_d       = 1'b0;
                        mosi_d       = 1'b0;
                        frame_done_d = 1'b1;
                        gap_d        = '0;
                        state_d      = (GAP_CYCLES == 0) ? IDLE : GAP;
                    end else begin
                        sclk_d  = 1'b0;
                        bit_d   = bit_cnt + 4'd1;
                        shreg_d = {shreg[9:0], 1'b0};
                        mosi_d  = shreg[9];
                    end
                end
            end
            GAP: begin
                if (gap_cnt == GAP_LAST) begin
                    state_d = IDLE;
                    select  = pick[3];
                end else begin
                    gap_d = gap_cnt + 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
        // Selection can close a gap directly, keeping back-to-back frames seamless.
        if (select) begin
            state_d = SHIFT;
            shreg_d = {pick[2:0], level_tbl[pick[2:0]]};
            mosi_d  = pick[2];
            sclk_d  = 1'b0;
            half_d  = '0;
            bit_d   = '0;
        end
    end

    always_ff @(posedge clk) begin
        // NOTE: state uses non-blocking assignments so all registers update from pre-edge values.
        if (reset) begin
            state_q    <= IDLE;
            sclk       <= 1'b0;
            mosi       <= 1'b0;
            busy       <= 1'b0;
            frame_done <= 1'b0;
            shreg      <= '0;
            half_cnt   <= '0;
            bit_cnt    <= '0;
            gap_cnt    <= '0;
        end else begin
            state_q    <= state_d;
            sclk       <= sclk_d;
            mosi       <= mosi_d;
            busy       <= (state_d != IDLE);
            frame_done <= frame_done_d;
            shreg      <= shreg_d;
            half_cnt   <= half_d;
            bit_cnt    <= bit_d;
            gap_cnt    <= gap_d;
        end
    end

    // NOTE: the level table is reset because the receiver also resets its levels to 0.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < 7; i++)
                level_tbl[i] <= '0;
            dirty_q   <= '0;
            last_sent <= 3'd6;
        end else begin
            if (select) begin
                dirty_q[pick[2:0]] <= 1'b0;
                last_sent          <= pick[2:0];
            end
            // A same-cycle write wins over the clear, forcing a later retransmit.
            if (wr_ok) begin
                level_tbl[wr_addr] <= wr_data;
                dirty_q[wr_addr]   <= 1'b1;
            end
        end
    end
endmodule

// File: tb/tb_pwm_level_spi_tx.sv
// Directed bench for pwm_level_spi_tx (CLK_DIV=4, GAP_CYCLES=2): decodes frames off
// sclk rises and compares them and the link timing to hand-computed values.
module tb_pwm_level_spi_tx;
    localparam int CLK_DIV = 4;
    localparam int GAP     = 2;

    logic       clk, reset, wr_en;
    logic [2:0] wr_addr;
    logic [7:0] wr_data;
    logic       sclk, mosi, busy, frame_done;
    logic [6:0] dirty;

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;
    int fd_count = 0;
    int sel_cyc, rise_cyc, fd_cyc, fd_prev;

    logic [10:0] frames[$];
    logic [10:0] shift_acc = '0;
    int          nbits     = 0;
    logic        sclk_prev = 1'b0;

    pwm_level_spi_tx #(.CLK_DIV(CLK_DIV), .GAP_CYCLES(GAP)) dut (
        .clk(clk), .reset(reset), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
        .sclk(sclk), .mosi(mosi), .busy(busy), .dirty(dirty), .frame_done(frame_done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc++;

    // Receiver model: sample mosi while sclk is high, one bit per rising edge.
    always @(negedge clk) begin
        if (reset) begin
            nbits     = 0;
            sclk_prev = 1'b0;
        end else begin
            if (sclk && !sclk_prev) begin
                shift_acc = {shift_acc[9:0], mosi};
                nbits++;
                if (nbits == 11) begin
                    frames.push_back(shift_acc);
                    nbits = 0;
                end
            end
            sclk_prev = sclk;
            if (frame_done) fd_count++;
        end
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic do_write(input logic [2:0] a, input logic [7:0] d);
        wr_en = 1'b1; wr_addr = a; wr_data = d;
        @(negedge clk);
        wr_en = 1'b0;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        repeat (3) @(negedge clk);
        reset = 1'b0;
        frames.delete();
    endtask

    task automatic wait_busy(input logic val, input int limit, input string tag);
        int n = 0;
        while (busy !== val && n < limit) begin
            @(negedge clk);
            n++;
        end
        if (busy !== val) check(tag, busy, val);
    endtask

    task automatic wait_fd(input int limit, input string tag);
        int n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (frame_done !== 1'b1 && n < limit);
        if (frame_done !== 1'b1) check(tag, frame_done, 1'b1);
        fd_cyc = cyc;
    endtask

    task automatic pop_frame(input string tag, input logic [10:0] exp);
        if (frames.size() == 0) check(tag, 32'hDEAD, exp);
        else check(tag, frames.pop_front(), exp);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic bad;
        reset = 1'b1; wr_en = 1'b0; wr_addr = '0; wr_data = '0;
        repeat (3) @(negedge clk);
        check("rst_sclk", sclk, 0);
        check("rst_mosi", mosi, 0);
        check("rst_busy", busy, 0);
        check("rst_dirty", dirty, 0);
        check("rst_fd", frame_done, 0);
        reset = 1'b0;

        bad = 1'b0;
        repeat (100) begin
            @(negedge clk);
            if (sclk || mosi || busy || dirty != 0 || frame_done) bad = 1'b1;
        end
        check("idle_quiet", bad, 0);
        check("idle_no_fd", fd_count, 0);

        // Single frame ch3=0xA5 with timing checks.
        do_write(3'd3, 8'hA5);
        check("wr_dirty", dirty, 7'h08);
        check("wr_busy_low", busy, 0);
        wait_busy(1'b1, 5, "sel_timeout");
        sel_cyc = cyc;
        check("sel_dirty_clr", dirty, 0);
        check("sel_mosi_msb", mosi, 0);
        while (!sclk && cyc - sel_cyc < 20) @(negedge clk);
        rise_cyc = cyc;
        check("first_rise", rise_cyc - sel_cyc, CLK_DIV);
        wait_fd(200, "fd_timeout");
        check("fd_latency", fd_cyc - sel_cyc, 22 * CLK_DIV);
        check("fd_sclk", sclk, 0);
        check("fd_mosi", mosi, 0);
        @(negedge clk);
        check("fd_one_cycle", frame_done, 0);
        check("gap_busy", busy, 1);
        wait_busy(1'b0, 20, "busy_fall_timeout");
        check("busy_fall", cyc - sel_cyc, 22 * CLK_DIV + GAP);
        pop_frame("frame_ch3", 11'b011_10100101);

        // Coalescing: pointer stays at 6 after a ch6 frame, queued writes go out ch1 then ch5.
        do_reset();
        do_write(3'd6, 8'h77);
        wait_busy(1'b1, 5, "sel6_timeout");
        repeat (5) @(negedge clk);
        do_write(3'd5, 8'h10);
        do_write(3'd1, 8'h20);
        do_write(3'd5, 8'h30);
        check("coal_dirty", dirty, 7'h22);
        wait_fd(200, "fd6_timeout");
        fd_prev = fd_cyc;
        wait_fd(200, "fd1_timeout");
        check("b2b_period1", fd_cyc - fd_prev, 22 * CLK_DIV + GAP);
        fd_prev = fd_cyc;
        wait_fd(200, "fd5_timeout");
        check("b2b_period2", fd_cyc - fd_prev, 22 * CLK_DIV + GAP);
        wait_busy(1'b0, 20, "coal_idle_timeout");
        repeat (20) @(negedge clk);
        check("coal_dirty_end", dirty, 0);
        check("coal_busy_end", busy, 0);
        pop_frame("frame_ch6", {3'd6, 8'h77});
        pop_frame("frame_ch1", {3'd1, 8'h20});
        pop_frame("frame_ch5", {3'd5, 8'h30});
        check("coal_count", frames.size(), 0);

        // In-flight rewrite of ch2 forces a retransmit with the new level.
        do_write(3'd2, 8'h11);
        wait_busy(1'b1, 5, "sel2_timeout");
        repeat (10) @(negedge clk);
        do_write(3'd2, 8'hFF);
        check("inflight_dirty", dirty, 7'h04);
        wait_fd(200, "fd2a_timeout");
        check("gap_dirty2", dirty, 7'h04);
        @(negedge clk);
        check("gap2_dirty2", dirty, 7'h04);
        check("gap2_busy", busy, 1);
        @(negedge clk);
        check("resel_dirty", dirty, 0);
        check("resel_busy", busy, 1);
        wait_fd(200, "fd2b_timeout");
        wait_busy(1'b0, 20, "ch2_idle_timeout");
        pop_frame("frame_ch2_old", {3'd2, 8'h11});
        pop_frame("frame_ch2_new", {3'd2, 8'hFF});
        check("ch2_count", frames.size(), 0);

        // Address 7 is ignored.
        do_write(3'd7, 8'h55);
        check("addr7_dirty", dirty, 0);
        bad = 1'b0;
        repeat (40) begin
            @(negedge clk);
            if (busy || sclk) bad = 1'b1;
        end
        check("addr7_idle", bad, 0);
        check("addr7_frames", frames.size(), 0);

        // Reset during bit 5 of a ch4 frame (frame bit 5 is 1).
        do_write(3'd4, 8'h3C);
        wait_busy(1'b1, 5, "sel4_timeout");
        repeat (45) @(negedge clk);
        check("bit5_sclk", sclk, 1);
        check("bit5_mosi", mosi, 1);
        reset = 1'b1;
        @(negedge clk);
        check("midrst_sclk", sclk, 0);
        check("midrst_mosi", mosi, 0);
        check("midrst_busy", busy, 0);
        check("midrst_dirty", dirty, 0);
        reset = 1'b0;
        frames.delete();
        do_write(3'd0, 8'h9A);
        wait_busy(1'b1, 5, "sel0_timeout");
        wait_fd(200, "fd0_timeout");
        wait_busy(1'b0, 20, "ch0_idle_timeout");
        pop_frame("frame_after_rst", {3'd0, 8'h9A});
        check("after_rst_count", frames.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
